rptr_empty_ctrl: RTL and testbench

Read-side pointer and flag controller for the asynchronous dual-clock FIFO, running entirely in the read clock domain. It synchronises the raw Gray-coded write pointer internally and advances a binary/Gray read pointer pair. It produces registered empty, almost-empty and fill-level outputs, and traps underflow attempts. It replaces the fixed-width read-pointer/empty block and sits between the dual-port RAM read port and the read-side consumer.

---
 rtl/fifo_async_pkg.sv | 48 ++++
 rtl/sync_ff_chain.sv | 28 ++
 rtl/rptr_empty_ctrl.sv | 129 ++++++++++++
 tb/tb_rptr_empty_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_async_pkg.sv
// Shared helpers for the dual-clock FIFO pointer controllers: Gray/binary
// conversion and address-width derivation, common to read and write sides.
package fifo_async_pkg;

  // Widest pointer the conversion helpers handle; callers zero-extend into it.
  localparam int unsigned PtrMaxW = 32;

  function automatic int unsigned addr_width(input int unsigned depth);
    return $clog2(depth);
  endfunction

  function automatic bit is_pow2(input int unsigned value);
    return (value != 0) && ((value & (value - 1)) == 0);
  endfunction

  function automatic logic [PtrMaxW-1:0] width_mask(input int unsigned width);
    logic [PtrMaxW-1:0] mask;
    mask = '0;
    for (int i = 0; i < int'(PtrMaxW); i++) begin
      if (i < int'(width)) mask[i] = 1'b1;
    end
    return mask;
  endfunction

  function automatic logic [PtrMaxW-1:0] bin2gray(input logic [PtrMaxW-1:0] bin,
                                                   input int unsigned       width);
    logic [PtrMaxW-1:0] b;
    b = bin & width_mask(width);
    return b ^ (b >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits at and above it.
  function automatic logic [PtrMaxW-1:0] gray2bin(input logic [PtrMaxW-1:0] gray,
                                                   input int unsigned       width);
    logic [PtrMaxW-1:0] bin;
    logic               acc;
    bin = '0;
    acc = 1'b0;
    for (int i = int'(PtrMaxW) - 1; i >= 0; i--) begin
      if (i < int'(width)) begin
        acc    = acc ^ gray[i];
        bin[i] = acc;
      end
    end
    return bin;
  endfunction

endpackage

// File: rtl/sync_ff_chain.sv
// Multi-flop synchroniser for Gray-coded pointers crossing clock domains.
// Asynchronous active-high reset clears every stage.
module sync_ff_chain #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [STAGES-1:0][WIDTH-1:0] stage_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_q <= '0;
    end else begin
      stage_q[0] <= d;
      for (int i = 1; i < int'(STAGES); i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q = stage_q[STAGES-1];

endmodule

// File: rtl/rptr_empty_ctrl.sv
// Read-side pointer/flag controller of the async FIFO (read clock domain only).
// Define RPTR_AEMPTY_EN to build the fill-level subtractor, rd_level and aempty.
module rptr_empty_ctrl
  import fifo_async_pkg::*;
#(
  parameter int unsigned DEPTH         = 1024,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned AEMPTY_THRESH = 4,
  localparam int unsigned AW           = addr_width(DEPTH)
) (
  input  logic        clk_r,
  input  logic        rst_r,
  input  logic        rd_req,
  input  logic        clr_underflow,
  input  logic [AW:0] wptr_gray,
  output logic        rd_en,
  output logic [AW-1:0] rd_addr,
  output logic [AW:0] rptr_gray,
  output logic        empty,
  output logic        aempty,
  output logic [AW:0] rd_level,
  output logic        underflow
);

  localparam int unsigned PW = AW + 1;

  if (!is_pow2(DEPTH) || DEPTH < 4) begin : g_bad_depth
    $error("DEPTH must be a power of two and at least 4");
  end
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_stages
    $error("SYNC_STAGES must be 2..4");
  end
  if (AEMPTY_THRESH < 1 || AEMPTY_THRESH >= DEPTH) begin : g_bad_thresh
    $error("AEMPTY_THRESH must be 1..DEPTH-1");
  end

  logic [PW-1:0] wq_gray;
  logic [PW-1:0] rptr_bin_q;
  logic [PW-1:0] rptr_gray_q;
  logic [PW-1:0] rptr_next;
  logic [PW-1:0] rptr_gray_next;
  logic          empty_q;
  logic          empty_d;
  logic          underflow_q;
  logic          underflow_d;

  sync_ff_chain #(
    .WIDTH  (PW),
    .STAGES (SYNC_STAGES)
  ) u_wptr_sync (
    .clk (clk_r),
    .rst (rst_r),
    .d   (wptr_gray),
    .q   (wq_gray)
  );

  assign rd_en          = rd_req & ~empty_q;
  assign rptr_next      = rptr_bin_q + PW'(rd_en);
  assign rptr_gray_next = PW'(bin2gray(PtrMaxW'(rptr_next), PW));
  // Pessimistic: wq_gray lags the real write pointer, so empty never clears early.
  assign empty_d        = (rptr_gray_next == wq_gray);

  always_comb begin
    underflow_d = underflow_q;
    if (rd_req && empty_q) begin
      underflow_d = 1'b1;
    end else if (clr_underflow) begin
      underflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk_r or posedge rst_r) begin
    if (rst_r) begin
      rptr_bin_q  <= '0;
      rptr_gray_q <= '0;
      empty_q     <= 1'b1;
      underflow_q <= 1'b0;
    end else begin
      rptr_bin_q  <= rptr_next;
      rptr_gray_q <= rptr_gray_next;
      empty_q     <= empty_d;
      underflow_q <= underflow_d;
    end
  end

`ifdef RPTR_AEMPTY_EN
  logic [PW-1:0] wq_bin;
  logic [PW-1:0] level_next;
  logic [PW-1:0] level_q;
  logic          aempty_d;
  logic          aempty_q;

  assign wq_bin     = PW'(gray2bin(PtrMaxW'(wq_gray), PW));
  // Modulo-2^PW difference is the true occupancy because it never exceeds DEPTH.
  assign level_next = wq_bin - rptr_next;
  assign aempty_d   = (PtrMaxW'(level_next) <= AEMPTY_THRESH);

  always_ff @(posedge clk_r or posedge rst_r) begin
    if (rst_r) begin
      level_q  <= '0;
      aempty_q <= 1'b1;
    end else begin
      level_q  <= level_next;
      aempty_q <= aempty_d;
    end
  end

  assign rd_level = level_q;
  assign aempty   = aempty_q;
`else
  assign rd_level = '0;
  assign aempty   = empty_q;
`endif

  assign rd_addr   = rptr_bin_q[AW-1:0];
  assign rptr_gray = rptr_gray_q;
  assign empty     = empty_q;
  assign underflow = underflow_q;

`ifndef SYNTHESIS
  a_gray_one_bit : assert property (@(posedge clk_r) disable iff (rst_r)
    $countones(rptr_gray_q ^ $past(rptr_gray_q)) <= 1);
`ifdef RPTR_AEMPTY_EN
  a_empty_level : assert property (@(posedge clk_r) disable iff (rst_r)
    empty_q == (level_q == '0));
`endif
`endif

endmodule

// File: tb/tb_rptr_empty_ctrl.sv
// Self-checking bench for rptr_empty_ctrl (DEPTH=16, SYNC_STAGES=2, AEMPTY_THRESH=4),
// tracking occupancy as plain write/read counts.
module tb_rptr_empty_ctrl;

  localparam int unsigned DEPTH  = 16;
  localparam int unsigned THRESH = 4;

  logic       clk_r = 1'b0;
  logic       rst_r = 1'b0;
  logic       rd_req = 1'b0;
  logic       clr_underflow = 1'b0;
  logic [4:0] wptr_gray = '0;
  logic       rd_en;
  logic [3:0] rd_addr;
  logic [4:0] rptr_gray;
  logic       empty;
  logic       aempty;
  logic [4:0] rd_level;
  logic       underflow;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: words written/read so far, and write count as seen through the synchroniser.
  int wcnt, rcnt, hist0, hist1, m_level;
  bit m_empty, m_uf;

  typedef struct {
    logic rd_req;
    logic clr;
    logic exp_rd_en;
    logic exp_uf;
    logic exp_empty;
  } vec_t;

  vec_t vt[5];

  rptr_empty_ctrl #(
    .DEPTH         (DEPTH),
    .SYNC_STAGES   (2),
    .AEMPTY_THRESH (THRESH)
  ) dut (
    .clk_r         (clk_r),
    .rst_r         (rst_r),
    .rd_req        (rd_req),
    .clr_underflow (clr_underflow),
    .wptr_gray     (wptr_gray),
    .rd_en         (rd_en),
    .rd_addr       (rd_addr),
    .rptr_gray     (rptr_gray),
    .empty         (empty),
    .aempty        (aempty),
    .rd_level      (rd_level),
    .underflow     (underflow)
  );

  always #5 clk_r = ~clk_r;

  function automatic logic [4:0] to_gray(input int n);
    logic [4:0] b;
    b = 5'(n % 32);
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  function automatic int exp_level();
`ifdef RPTR_AEMPTY_EN
    return m_level;
`else
    return 0;
`endif
  endfunction

  function automatic bit exp_aempty();
`ifdef RPTR_AEMPTY_EN
    return m_level <= int'(THRESH);
`else
    return m_empty;
`endif
  endfunction

  task automatic model_reset();
    wcnt = 0; rcnt = 0; hist0 = 0; hist1 = 0; m_level = 0;
    m_empty = 1'b1; m_uf = 1'b0;
  endtask

  task automatic model_edge();
    int vis;
    if (rd_req && m_empty) m_uf = 1'b1;
    else if (clr_underflow) m_uf = 1'b0;
    if (rd_req && !m_empty) rcnt++;
    vis     = hist1;
    hist1   = hist0;
    hist0   = wcnt;
    m_level = vis - rcnt;
    m_empty = (m_level == 0);
  endtask

  task automatic set_w(input int n);
    wcnt      = n;
    wptr_gray = to_gray(n);
  endtask

  task automatic check_regs();
    check("empty", empty, m_empty);
    check("aempty", aempty, exp_aempty());
    check("rd_level", rd_level, exp_level());
    check("rptr_gray", rptr_gray, to_gray(rcnt));
    check("rd_addr", rd_addr, rcnt % DEPTH);
    check("underflow", underflow, m_uf);
  endtask

  // Inputs are already applied; check the combinational strobe, clock once, check registers.
  task automatic tick();
    logic [4:0] prev;
    #1;
    check("rd_en", rd_en, rd_req && !m_empty);
    prev = rptr_gray;
    @(posedge clk_r);
    #1;
    model_edge();
    check_regs();
    check("gray_step", ($countones(prev ^ rptr_gray) <= 1), 1);
  endtask

  // Asserts reset away from any clock edge and checks outputs before the next edge.
  task automatic do_reset();
    #3;
    rst_r = 1'b1;
    rd_req = 1'b0;
    clr_underflow = 1'b0;
    set_w(0);
    #1;
    check("rst_empty", empty, 1);
    check("rst_aempty", aempty, 1);
    check("rst_level", rd_level, 0);
    check("rst_rptr_gray", rptr_gray, 0);
    check("rst_underflow", underflow, 0);
    check("rst_rd_en", rd_en, 0);
    repeat (2) @(posedge clk_r);
    #1;
    rst_r = 1'b0;
    model_reset();
  endtask

  initial begin
    int lvl_exp;
    model_reset();
`ifdef RPTR_AEMPTY_EN
    lvl_exp = 1;
`else
    lvl_exp = 0;
`endif

    vt[0] = '{rd_req: 1'b1, clr: 1'b0, exp_rd_en: 1'b0, exp_uf: 1'b1, exp_empty: 1'b1};
    vt[1] = '{rd_req: 1'b0, clr: 1'b0, exp_rd_en: 1'b0, exp_uf: 1'b1, exp_empty: 1'b1};
    vt[2] = '{rd_req: 1'b1, clr: 1'b1, exp_rd_en: 1'b0, exp_uf: 1'b1, exp_empty: 1'b1};
    vt[3] = '{rd_req: 1'b0, clr: 1'b1, exp_rd_en: 1'b0, exp_uf: 1'b0, exp_empty: 1'b1};
    vt[4] = '{rd_req: 1'b0, clr: 1'b0, exp_rd_en: 1'b0, exp_uf: 1'b0, exp_empty: 1'b1};

    do_reset();

    // Underflow trapping on an empty FIFO
    for (int i = 0; i < 5; i++) begin
      rd_req = vt[i].rd_req;
      clr_underflow = vt[i].clr;
      #1;
      check("tbl_rd_en", rd_en, vt[i].exp_rd_en);
      @(posedge clk_r);
      #1;
      model_edge();
      check("tbl_underflow", underflow, vt[i].exp_uf);
      check("tbl_empty", empty, vt[i].exp_empty);
      check("tbl_ptr", rptr_gray, 0);
      check_regs();
    end
    rd_req = 1'b0;
    clr_underflow = 1'b0;

    // Write visibility latency and last-word read
    do_reset();
    set_w(1);
    tick();
    check("lat_edge0", empty, 1);
    set_w(1);
    tick();
    check("lat_edge1", empty, 1);
    tick();
    check("lat_edge2", empty, 0);
    check("lat_level", rd_level, lvl_exp);
    rd_req = 1'b1;
    #1;
    check("lat_rd_en", rd_en, 1);
    check("lat_rd_addr", rd_addr, 0);
    tick();
    check("lat_empty_again", empty, 1);
    rd_req = 1'b0;

    // Fill to DEPTH then drain back-to-back
    do_reset();
    set_w(16);
    repeat (3) tick();
    check("fill_level", rd_level, lvl_exp * 16);
    rd_req = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k == 11) check("drain_aempty_at5", aempty, 0);
      if (k == 12) check("drain_aempty_at4", aempty, lvl_exp);
      if (k == 15) check("drain_not_empty", empty, 0);
    end
    check("drain_empty", empty, 1);
    check("drain_rptr_gray", rptr_gray, 5'b11000);
    rd_req = 1'b0;

    // Reset while streaming reads at level 9
    do_reset();
    set_w(9);
    repeat (3) tick();
    check("burst_level", rd_level, lvl_exp * 9);
    rd_req = 1'b1;
    repeat (2) tick();
    do_reset();

    // Randomised traffic with alternating read pressure; many pointer wraps
    for (int i = 0; i < 1200; i++) begin
      if ($urandom_range(0, 1) == 1 && (wcnt - rcnt) < int'(DEPTH)) set_w(wcnt + 1);
      if ((i % 200) < 100) rd_req = ($urandom_range(0, 2) == 0);
      else rd_req = ($urandom_range(0, 3) != 0);
      clr_underflow = ($urandom_range(0, 7) == 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
